// File: rtl/conv2_window_gen.sv
// conv2_window_gen: turns a raster stream of pixel words into 3x3 windows.
// Two line buffers hold the previous two rows; a 3x3 shift array forms the
// window, and a single output stage gives valid/ready flow control.
module conv2_window_gen #(
  parameter  int DATA_W = 32,
  parameter  int IMG_W  = 14,
  parameter  int IMG_H  = 14,
  localparam int RW     = $clog2(IMG_H),
  localparam int CW     = $clog2(IMG_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [8:0][DATA_W-1:0] data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RW-1:0]          out_row,
  output logic [CW-1:0]          out_col,
  output logic                   frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);

  state_e                   state_q, state_d;
  logic [RW-1:0]            r_q, r_d;
  logic [CW-1:0]            c_q, c_d;
  logic [DATA_W-1:0]        lb0_q [IMG_W];  // row r-1
  logic [DATA_W-1:0]        lb1_q [IMG_W];  // row r-2
  logic [8:0][DATA_W-1:0]   win_q, win_d;
  logic                     ov_q, ov_d;
  logic [RW-1:0]            orow_q, orow_d;
  logic [CW-1:0]            ocol_q, ocol_d;
  logic                     accept, last_pix, emit;

  assign accept   = in_valid & in_ready;
  assign last_pix = (r_q == R_LAST) && (c_q == C_LAST);
  // Columns 0-1 only refill the array; a window needs two rows above too.
  assign emit     = accept && (r_q >= RW'(2)) && (c_q >= CW'(2));

  assign data_out  = win_q;
  assign out_valid = ov_q;
  assign out_row   = orow_q;
  assign out_col   = ocol_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_pix) state_d = DRAIN;
      DRAIN:   if (ov_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; the final window taken in DRAIN is the end of the frame
  always_comb begin
    busy       = (state_q != IDLE);
    in_ready   = (state_q == RUN) && (!ov_q || out_ready);
    frame_done = (state_q == DRAIN) && ov_q && out_ready;
  end

  // Datapath next state: raster counters, window shift, output stage
  always_comb begin
    r_d    = r_q;
    c_d    = c_q;
    win_d  = win_q;
    ov_d   = ov_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    if (state_q == IDLE && start) begin
      r_d = '0;
      c_d = '0;
    end else if (accept) begin
      if (c_q == C_LAST) begin
        c_d = '0;
        r_d = r_q + RW'(1);
      end else begin
        c_d = c_q + CW'(1);
      end
    end
    if (accept) begin
      win_d[0] = win_q[1]; win_d[1] = win_q[2]; win_d[2] = lb1_q[c_q];
      win_d[3] = win_q[4]; win_d[4] = win_q[5]; win_d[5] = lb0_q[c_q];
      win_d[6] = win_q[7]; win_d[7] = win_q[8]; win_d[8] = in_data;
    end
    // A take and a fresh load in the same cycle keep out_valid high.
    if (emit) begin
      ov_d   = 1'b1;
      orow_d = r_q - RW'(2);
      ocol_d = c_q - CW'(2);
    end else if (out_ready) begin
      ov_d   = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      c_q    <= '0;
      win_q  <= '0;
      ov_q   <= 1'b0;
      orow_q <= '0;
      ocol_q <= '0;
    end else begin
      r_q    <= r_d;
      c_q    <= c_d;
      win_q  <= win_d;
      ov_q   <= ov_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
    end
  end

  // Line buffers: row r-1 ages into row r-2 as the new pixel lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else if (accept) begin
      lb1_q[c_q] <= lb0_q[c_q];
      lb0_q[c_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_conv2_window_gen.sv
// Directed bench for conv2_window_gen on a 4x4 frame: basic frame,
// back-to-back frames, gaps + stall + ignored start, mid-frame reset.
module tb_conv2_window_gen;
  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic [DW-1:0]       in_data = '0;
  logic                busy, in_ready, out_valid, frame_done;
  logic [8:0][DW-1:0]  data_out;
  logic [1:0]          out_row, out_col;
  int                  checks = 0;
  int                  failures = 0;

  conv2_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_in_ready"},   in_ready,   0);
    chk({tag, "_out_valid"},  out_valid,  0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_out_row"},    out_row,    0);
    chk({tag, "_out_col"},    out_col,    0);
    chk({tag, "_data_out"},   data_out,   0);
  endtask

  // Runs one 4x4 frame with pixels base..base+15; windows must come out in
  // raster order with data_out[k] = pix(row+k/3, col+k%3).
  task automatic run_frame(input int base, input bit gaps, input int stall_at, input bit pokes);
    int pi = 0;
    int nw = 0;
    int fd = 0;
    int cyc = 0;
    bit dpoke = 0;
    int er, ec;
    logic [8:0][DW-1:0] exp, pdo;
    logic pov = 0;
    logic prdy = 1;
    logic [1:0] prow = 0, pcol = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (busy && cyc < 300) begin
      in_valid  = (pi < 16) && !(gaps && (cyc % 3 == 1));
      in_data   = DW'(base + pi);
      out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
      start     = pokes && (cyc == 3 || (pi == 16 && !dpoke));
      if (start && pi == 16) dpoke = 1;
      #1;
      if (pov && !prdy) begin
        chk("hold_data", data_out, pdo);
        chk("hold_row",  out_row,  prow);
        chk("hold_col",  out_col,  pcol);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        er = nw / 2;
        ec = nw % 2;
        for (int k = 0; k < 9; k++) exp[k] = DW'(base + (er + k / 3) * W + ec + k % 3);
        chk("win_data", data_out, exp);
        chk("win_row",  out_row,  er);
        chk("win_col",  out_col,  ec);
        nw++;
      end
      if (frame_done) fd++;
      if (in_valid && in_ready) pi++;
      pov  = out_valid;
      prdy = out_ready;
      pdo  = data_out;
      prow = out_row;
      pcol = out_col;
      @(posedge clk);
      #1;
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("frame_terminates", (cyc < 300), 1);
    chk("window_count", nw, 4);
    chk("frame_done_count", fd, 1);
    chk("busy_after_frame", busy, 0);
    chk("out_valid_after_frame", out_valid, 0);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Plain frame, then a second frame started right after the first ends
    run_frame(0, 0, 1000, 0);
    run_frame(100, 0, 1000, 0);

    // Input gaps, a 5-cycle output stall, and start pulses in RUN and DRAIN
    run_frame(0, 1, 16, 1);
    tick();
    chk("start_not_latched", busy, 0);

    // Reset after 7 pixels, with start held during reset
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = DW'(i);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk_zero("midreset");
    tick();
    chk_zero("midreset_start");
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk("post_reset_idle", busy, 0);

    // Fresh frame after reset must carry no stale data
    run_frame(0, 0, 1000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
